// File: rtl/tcam_wr_if.sv
// tcam_wr_if: request and write-port bundle for tcam_wr_arbiter.
//   master : requester side (drives reqN_valid/addr/key/mask/action, sees reqN_ready)
//            and the view of the TCAM/action write port it produces.
//   slave  : arbiter side (drives reqN_ready and the TCAM/action write port).
// Requester 0 is the CPU MMIO path and requester 1 is the learn engine.
interface tcam_wr_if #(
  parameter int KEY_W    = 128,
  parameter int IDX_W    = 4,
  parameter int ACTION_W = 64
);
  logic                req0_valid;
  logic                req0_ready;
  logic [IDX_W-1:0]    req0_addr;
  logic [KEY_W-1:0]    req0_key;
  logic [KEY_W-1:0]    req0_mask;
  logic [ACTION_W-1:0] req0_action;

  logic                req1_valid;
  logic                req1_ready;
  logic [IDX_W-1:0]    req1_addr;
  logic [KEY_W-1:0]    req1_key;
  logic [KEY_W-1:0]    req1_mask;
  logic [ACTION_W-1:0] req1_action;

  logic                tcam_wr_en;
  logic                tcam_wr_is_mask;
  logic [IDX_W-1:0]    tcam_wr_addr;
  logic [KEY_W-1:0]    tcam_wr_data;
  logic                action_wr_en;
  logic [IDX_W-1:0]    action_wr_addr;
  logic [ACTION_W-1:0] action_wr_data;

  modport master (
    output req0_valid, req0_addr, req0_key, req0_mask, req0_action,
    output req1_valid, req1_addr, req1_key, req1_mask, req1_action,
    input  req0_ready, req1_ready,
    input  tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data,
    input  action_wr_en, action_wr_addr, action_wr_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_key, req0_mask, req0_action,
    input  req1_valid, req1_addr, req1_key, req1_mask, req1_action,
    output req0_ready, req1_ready,
    output tcam_wr_en, tcam_wr_is_mask, tcam_wr_addr, tcam_wr_data,
    output action_wr_en, action_wr_addr, action_wr_data
  );
endinterface

// File: rtl/tcam_wr_arbiter.sv
// tcam_wr_arbiter: shares the single TCAM/action write port between the CPU
// MMIO path (requester 0) and the learn engine (requester 1). Each grant
// commits one entry as an atomic mask -> key -> action write sequence.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   freeze            : blocks new grants (sampled only while idle)
//   bus (slave)       : request handshakes and the TCAM/action write port
//   upd_busy, upd_idx : entry currently being rewritten (for hit discard)
//   done, done_id     : completion pulse and owning requester
//   err               : out-of-range request dropped (same cycle as its ready)
//   cnt0, cnt1        : committed-entry counters, wrap at 16 bits
//
// state   | meaning
// IDLE    | waiting for a request; grant decision is made here
// WR_MASK | mask plane write of the latched entry
// WR_KEY  | key plane write of the latched entry
// WR_ACT  | action table write; done follows on the next cycle
module tcam_wr_arbiter #(
  parameter int KEY_W    = 128,
  parameter int ENTRIES  = 16,
  parameter int IDX_W    = $clog2(ENTRIES),
  parameter int ACTION_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  tcam_wr_if.slave         bus,
  output logic             upd_busy,
  output logic [IDX_W-1:0] upd_idx,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  typedef enum logic [1:0] {IDLE, WR_MASK, WR_KEY, WR_ACT} state_t;

  localparam logic [IDX_W:0] ENTRIES_W = (IDX_W+1)'(ENTRIES);

  state_t              state;
  logic                last_grant;
  logic                id_q;
  logic [KEY_W-1:0]    key_q;
  logic [ACTION_W-1:0] act_q;

  logic             grant;
  logic             pick1;
  logic             in_range;
  logic [IDX_W-1:0] sel_addr;

  // Round-robin: with both valid, the requester not granted last wins.
  assign grant    = (state == IDLE) && !freeze && (bus.req0_valid || bus.req1_valid);
  assign pick1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign sel_addr = pick1 ? bus.req1_addr : bus.req0_addr;

  generate
    if (ENTRIES == (1 << IDX_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = {1'b0, sel_addr} < ENTRIES_W;
    end
  endgenerate

  assign bus.req0_ready = grant && !pick1;
  assign bus.req1_ready = grant && pick1;
  // err must coincide with the dropping ready pulse, so it is decoded
  // alongside ready rather than registered.
  assign err = grant && !in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      id_q                <= 1'b0;
      key_q               <= '0;
      act_q               <= '0;
      bus.tcam_wr_en      <= 1'b0;
      bus.tcam_wr_is_mask <= 1'b0;
      bus.tcam_wr_addr    <= '0;
      bus.tcam_wr_data    <= '0;
      bus.action_wr_en    <= 1'b0;
      bus.action_wr_addr  <= '0;
      bus.action_wr_data  <= '0;
      upd_busy            <= 1'b0;
      upd_idx             <= '0;
      done                <= 1'b0;
      done_id             <= 1'b0;
      cnt0                <= '0;
      cnt1                <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= pick1;
            // Out-of-range requests are consumed but never written.
            if (in_range) begin
              id_q                <= pick1;
              key_q               <= pick1 ? bus.req1_key : bus.req0_key;
              act_q               <= pick1 ? bus.req1_action : bus.req0_action;
              bus.tcam_wr_en      <= 1'b1;
              bus.tcam_wr_is_mask <= 1'b1;
              bus.tcam_wr_addr    <= sel_addr;
              bus.tcam_wr_data    <= pick1 ? bus.req1_mask : bus.req0_mask;
              bus.action_wr_addr  <= sel_addr;
              upd_busy            <= 1'b1;
              upd_idx             <= sel_addr;
              state               <= WR_MASK;
            end
          end
        end
        WR_MASK: begin
          bus.tcam_wr_is_mask <= 1'b0;
          bus.tcam_wr_data    <= key_q;
          state               <= WR_KEY;
        end
        WR_KEY: begin
          bus.tcam_wr_en     <= 1'b0;
          bus.action_wr_en   <= 1'b1;
          bus.action_wr_data <= act_q;
          state              <= WR_ACT;
        end
        WR_ACT: begin
          bus.action_wr_en <= 1'b0;
          upd_busy         <= 1'b0;
          done             <= 1'b1;
          done_id          <= id_q;
          if (id_q) cnt1 <= cnt1 + 16'd1;
          else      cnt0 <= cnt0 + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_wr_arbiter.sv
// Directed bench for tcam_wr_arbiter: a 16-entry instance for the main
// sequencing/arbitration behaviour and a 12-entry instance for the
// out-of-range drop. Inputs change and outputs are sampled 1 ns after the
// falling edge.
module tb_tcam_wr_arbiter;
  localparam int KEY_W    = 128;
  localparam int ACTION_W = 64;
  localparam int IDX_W    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, freeze, freeze12;
  logic upd_busy, done, done_id, err;
  logic [IDX_W-1:0] upd_idx;
  logic [15:0] cnt0, cnt1;
  logic upd_busy12, done12, done_id12, err12;
  logic [IDX_W-1:0] upd_idx12;
  logic [15:0] cnt0_12, cnt1_12;

  tcam_wr_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .ACTION_W(ACTION_W)) bus ();
  tcam_wr_if #(.KEY_W(KEY_W), .IDX_W(IDX_W), .ACTION_W(ACTION_W)) bus12 ();

  tcam_wr_arbiter #(.KEY_W(KEY_W), .ENTRIES(16), .ACTION_W(ACTION_W)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .bus(bus),
    .upd_busy(upd_busy), .upd_idx(upd_idx), .done(done), .done_id(done_id),
    .err(err), .cnt0(cnt0), .cnt1(cnt1)
  );

  tcam_wr_arbiter #(.KEY_W(KEY_W), .ENTRIES(12), .ACTION_W(ACTION_W)) dut12 (
    .clk(clk), .reset(reset), .freeze(freeze12), .bus(bus12),
    .upd_busy(upd_busy12), .upd_idx(upd_idx12), .done(done12), .done_id(done_id12),
    .err(err12), .cnt0(cnt0_12), .cnt1(cnt1_12)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam logic [KEY_W-1:0]    K0 = {16{8'hA5}};
  localparam logic [KEY_W-1:0]    M0 = {{8{8'hFF}}, {8{8'h00}}};
  localparam logic [KEY_W-1:0]    K1 = {4{32'h1357_9BDF}};
  localparam logic [KEY_W-1:0]    M1 = {4{32'hF0F0_0F0F}};
  localparam logic [ACTION_W-1:0] A0 = 64'h1234;
  localparam logic [ACTION_W-1:0] A1 = 64'hDEAD_BEEF_0000_0042;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus12.req0_valid = 1'b0;
    bus12.req1_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic set_req0(input logic [3:0] a, input logic [KEY_W-1:0] k,
                          input logic [KEY_W-1:0] m, input logic [ACTION_W-1:0] act);
    bus.req0_addr = a; bus.req0_key = k; bus.req0_mask = m; bus.req0_action = act;
  endtask

  task automatic set_req1(input logic [3:0] a, input logic [KEY_W-1:0] k,
                          input logic [KEY_W-1:0] m, input logic [ACTION_W-1:0] act);
    bus.req1_addr = a; bus.req1_key = k; bus.req1_mask = m; bus.req1_action = act;
  endtask

  initial begin
    logic seen;
    logic exp1;
    logic [3:0] exp_addr;

    reset = 1'b1; freeze = 1'b0; freeze12 = 1'b0;
    clear_reqs;
    set_req0(4'd0, '0, '0, '0);
    set_req1(4'd0, '0, '0, '0);
    bus12.req0_addr = '0; bus12.req0_key = '0; bus12.req0_mask = '0; bus12.req0_action = '0;
    bus12.req1_addr = '0; bus12.req1_key = '0; bus12.req1_mask = '0; bus12.req1_action = '0;
    repeat (3) tick;

    // Reset values
    chk("rst_tcam_en", bus.tcam_wr_en, 1'b0);
    chk("rst_act_en", bus.action_wr_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", upd_busy, 1'b0);
    chk("rst_data", bus.tcam_wr_data, '0);
    chk("rst_cnt0", cnt0, 16'd0);
    chk("rst_cnt1", cnt1, 16'd0);
    reset = 1'b0;
    tick;

    // Single CPU request, addr 5
    set_req0(4'd5, K0, M0, A0);
    bus.req0_valid = 1'b1;
    #1;
    chk("single_ready0", bus.req0_ready, 1'b1);
    chk("single_ready1", bus.req1_ready, 1'b0);
    chk("single_err", err, 1'b0);
    tick; // T+1
    bus.req0_valid = 1'b0;
    chk("single_m_en", bus.tcam_wr_en, 1'b1);
    chk("single_m_is", bus.tcam_wr_is_mask, 1'b1);
    chk("single_m_addr", bus.tcam_wr_addr, 4'd5);
    chk("single_m_data", bus.tcam_wr_data, M0);
    chk("single_busy", upd_busy, 1'b1);
    chk("single_idx", upd_idx, 4'd5);
    tick; // T+2
    chk("single_k_en", bus.tcam_wr_en, 1'b1);
    chk("single_k_is", bus.tcam_wr_is_mask, 1'b0);
    chk("single_k_data", bus.tcam_wr_data, K0);
    tick; // T+3
    chk("single_a_tcam", bus.tcam_wr_en, 1'b0);
    chk("single_a_en", bus.action_wr_en, 1'b1);
    chk("single_a_addr", bus.action_wr_addr, 4'd5);
    chk("single_a_data", bus.action_wr_data, A0);
    chk("single_a_busy", upd_busy, 1'b1);
    chk("single_a_done", done, 1'b0);
    tick; // T+4
    chk("single_done", done, 1'b1);
    chk("single_done_id", done_id, 1'b0);
    chk("single_cnt0", cnt0, 16'd1);
    chk("single_idle_busy", upd_busy, 1'b0);
    chk("single_idle_act", bus.action_wr_en, 1'b0);
    tick;
    chk("single_done_pulse", done, 1'b0);

    // Contention: both held valid for four back-to-back commits
    do_reset;
    set_req0(4'd2, K0, M0, A0);
    set_req1(4'd9, K1, M1, A1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp1 = (k % 2) == 1;
      exp_addr = exp1 ? 4'd9 : 4'd2;
      chk("rr_ready0", bus.req0_ready, !exp1);
      chk("rr_ready1", bus.req1_ready, exp1);
      if (k > 0) begin
        chk("rr_done", done, 1'b1);
        chk("rr_done_id", done_id, !exp1);
      end
      tick;
      chk("rr_m_excl", {bus.tcam_wr_en, bus.action_wr_en}, 2'b10);
      chk("rr_m_addr", bus.tcam_wr_addr, exp_addr);
      chk("rr_m_data", bus.tcam_wr_data, exp1 ? M1 : M0);
      tick;
      chk("rr_k_excl", {bus.tcam_wr_en, bus.action_wr_en}, 2'b10);
      chk("rr_k_data", bus.tcam_wr_data, exp1 ? K1 : K0);
      tick;
      chk("rr_a_excl", {bus.tcam_wr_en, bus.action_wr_en}, 2'b01);
      chk("rr_a_data", bus.action_wr_data, exp1 ? A1 : A0);
      chk("rr_a_addr", bus.action_wr_addr, exp_addr);
      tick;
    end
    chk("rr_last_done", done, 1'b1);
    chk("rr_last_id", done_id, 1'b1);
    chk("rr_cnt0", cnt0, 16'd2);
    chk("rr_cnt1", cnt1, 16'd2);
    clear_reqs;
    #1;
    chk("rr_no_extra", bus.req0_ready | bus.req1_ready, 1'b0);
    tick;

    // freeze holds off grants, but not an in-flight sequence
    do_reset;
    freeze = 1'b1;
    set_req1(4'd3, K1, M1, A1);
    bus.req1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      seen = seen | bus.req1_ready | bus.req0_ready | bus.tcam_wr_en;
      tick;
    end
    chk("frz_hold", seen, 1'b0);
    freeze = 1'b0;
    #1;
    chk("frz_release_ready1", bus.req1_ready, 1'b1);
    tick; // T+1
    bus.req1_valid = 1'b0;
    tick; // T+2
    freeze = 1'b1;
    tick; // T+3
    chk("frz_act_en", bus.action_wr_en, 1'b1);
    chk("frz_act_addr", bus.action_wr_addr, 4'd3);
    tick; // T+4
    chk("frz_done", done, 1'b1);
    chk("frz_done_id", done_id, 1'b1);
    chk("frz_cnt1", cnt1, 16'd1);
    freeze = 1'b0;

    // Reset in the middle of a sequence
    do_reset;
    set_req0(4'd7, K0, M0, A0);
    bus.req0_valid = 1'b1;
    #1;
    chk("mid_ready0", bus.req0_ready, 1'b1);
    tick; // T+1
    bus.req0_valid = 1'b0;
    tick; // T+2
    reset = 1'b1;
    tick; // T+3
    chk("mid_tcam_en", bus.tcam_wr_en, 1'b0);
    chk("mid_act_en", bus.action_wr_en, 1'b0);
    chk("mid_busy", upd_busy, 1'b0);
    chk("mid_addr", bus.tcam_wr_addr, 4'd0);
    chk("mid_data", bus.tcam_wr_data, '0);
    chk("mid_idx", upd_idx, 4'd0);
    reset = 1'b0;
    tick; // T+4
    chk("mid_no_done", done, 1'b0);
    chk("mid_no_act", bus.action_wr_en, 1'b0);
    chk("mid_cnt0", cnt0, 16'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("mid_ptr_ready0", bus.req0_ready, 1'b1);
    chk("mid_ptr_ready1", bus.req1_ready, 1'b0);
    clear_reqs;
    tick;

    // Counter wrap on requester 1
    force dut.cnt1 = 16'hFFFF;
    tick;
    release dut.cnt1;
    tick;
    chk("wrap_preload", cnt1, 16'hFFFF);
    set_req1(4'd1, K1, M1, A1);
    bus.req1_valid = 1'b1;
    #1;
    chk("wrap_ready1", bus.req1_ready, 1'b1);
    tick;
    bus.req1_valid = 1'b0;
    tick;
    tick;
    tick; // T+4
    chk("wrap_done", done, 1'b1);
    chk("wrap_cnt1", cnt1, 16'h0000);
    chk("wrap_cnt0", cnt0, 16'h0000);

    // 12-entry instance: addr 13 is dropped with err
    bus12.req0_addr = 4'd13;
    bus12.req0_key = K0;
    bus12.req0_mask = M0;
    bus12.req0_action = A0;
    bus12.req0_valid = 1'b1;
    #1;
    chk("oor_ready0", bus12.req0_ready, 1'b1);
    chk("oor_err", err12, 1'b1);
    tick;
    bus12.req0_valid = 1'b0;
    #1;
    chk("oor_err_pulse", err12, 1'b0);
    chk("oor_tcam_en", bus12.tcam_wr_en, 1'b0);
    chk("oor_busy", upd_busy12, 1'b0);
    tick;
    tick;
    tick;
    chk("oor_act_en", bus12.action_wr_en, 1'b0);
    chk("oor_done", done12, 1'b0);
    chk("oor_cnt0", cnt0_12, 16'd0);

    // In-range request on the 12-entry instance still commits
    bus12.req0_addr = 4'd11;
    bus12.req0_valid = 1'b1;
    #1;
    chk("ir12_err", err12, 1'b0);
    tick;
    bus12.req0_valid = 1'b0;
    chk("ir12_m_addr", bus12.tcam_wr_addr, 4'd11);
    tick;
    tick;
    tick;
    chk("ir12_done", done12, 1'b1);
    chk("ir12_cnt0", cnt0_12, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
